// File: rtl/coax_pkg.sv
// Shared constants and sequencer state encoding for the coax transmit queue.
package coax_pkg;

  localparam int COAX_WORD_WIDTH = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } coax_state_t;

endpackage

// File: rtl/coax_tx_queue_if.sv
// Host-side enqueue/start signals plus the coax_tx data/strobe handshake.
// Optional feature macro: COAX_TX_QUEUE_ERROR_EN adds the sticky error flag.
interface coax_tx_queue_if #(
  parameter int DEPTH = 16
);
  import coax_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [COAX_WORD_WIDTH-1:0] data;
  logic                       write_strobe;
  logic                       start_strobe;
  logic                       full;
  logic                       empty;
  logic [CW-1:0]              count;
  logic                       active;
  logic [COAX_WORD_WIDTH-1:0] tx_data;
  logic                       tx_strobe;
  logic                       tx_ready;
  logic                       tx_active;
`ifdef COAX_TX_QUEUE_ERROR_EN
  logic                       error;
`endif

  // Host plus coax_tx side.
  modport master (
    output data, write_strobe, start_strobe, tx_ready, tx_active,
    input  full, empty, count, active, tx_data, tx_strobe
`ifdef COAX_TX_QUEUE_ERROR_EN
    , input error
`endif
  );

  // The queue itself.
  modport slave (
    input  data, write_strobe, start_strobe, tx_ready, tx_active,
    output full, empty, count, active, tx_data, tx_strobe
`ifdef COAX_TX_QUEUE_ERROR_EN
    , output error
`endif
  );

endinterface

// File: rtl/coax_fifo.sv
// Single-clock FIFO with first-word-fall-through head. A push while full or a
// pop while empty is ignored; full/empty decode the registered count.
module coax_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/coax_tx_queue.sv
// Word queue and frame sequencer feeding coax_tx. A start strobe releases the
// queued words back-to-back as one frame; words written before the queue runs
// dry are appended to the frame in flight.
// Optional feature macro: COAX_TX_QUEUE_ERROR_EN (sticky overflow/misuse flag).
module coax_tx_queue
  import coax_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  coax_tx_queue_if.slave bus
);

  coax_state_t                state, state_nxt;
  logic                       strobe_nxt;
  logic [COAX_WORD_WIDTH-1:0] head;
  logic                       do_push;

  // Full is the registered flag, so a write while full drops even on a pop cycle.
  assign do_push = bus.write_strobe && !bus.full;

  coax_fifo #(.DEPTH(DEPTH), .WIDTH(COAX_WORD_WIDTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (do_push),
    .pop   (bus.tx_strobe),
    .din   (bus.data),
    .head  (head),
    .count (bus.count),
    .full  (bus.full),
    .empty (bus.empty)
  );

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: SEND hands off one word per ready period, WAIT holds until
  // coax_tx drops ready, DRAIN lets coax_tx finish the frame on its own.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.start_strobe && !bus.empty) state_nxt = SEND;
      SEND:  if (bus.empty)                      state_nxt = DRAIN;
             else if (bus.tx_ready)              state_nxt = WAIT;
      WAIT:  if (!bus.tx_ready)                  state_nxt = SEND;
      DRAIN: if (!bus.tx_active)                 state_nxt = IDLE;
      default:                                   state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; the strobe is registered below.
  always_comb begin
    strobe_nxt = (state == SEND) && !bus.empty && bus.tx_ready;
  end

  assign bus.active = (state != IDLE);

  // Strobe register; tx_data only changes on a strobe so it holds between words.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.tx_strobe <= 1'b0;
      bus.tx_data   <= '0;
    end else begin
      bus.tx_strobe <= strobe_nxt;
      if (strobe_nxt) bus.tx_data <= head;
    end
  end

`ifdef COAX_TX_QUEUE_ERROR_EN
  // Sticky flag: write into a full queue or start during a frame.
  always_ff @(posedge clk) begin
    if (reset) bus.error <= 1'b0;
    else if ((bus.write_strobe && bus.full) || (bus.start_strobe && bus.active))
      bus.error <= 1'b1;
  end
`endif

endmodule
